fft_frame_sched: RTL and testbench

Frame scheduler for the parallel 32-point FFT core. It arbitrates round-robin between two frame requesters and steers the selected requester's operand bank onto the FFT `inN_r` inputs. For each frame it pulses the FFT reset, waits for `out_en` or a timeout, and presents a tagged completion to a downstream consumer over a valid/ready handshake. It replaces manual reset sequencing between frames and sits directly above `top`.

---
 rtl/fft_frame_sched.sv | 120 ++++++++++++
 tb/tb_fft_frame_sched.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_sched.sv
// Frame scheduler for the 32-point FFT core: round-robin grant between two requesters,
// FFT reset sequencing, completion/timeout detection and a tagged valid/ready completion.
module fft_frame_sched #(
    parameter int LAT_MAX = 16,
    parameter int RST_CYC = 1,
    parameter int ID_W    = 4
) (
    input  logic            clk2,
    input  logic            rst,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    output logic            in_sel,
    output logic            in_load,
    output logic            fft_rst,
    input  logic            fft_out_en,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_src,
    output logic [ID_W-1:0] out_id,
    output logic            out_err,
    output logic            err_sticky,
    output logic            busy
);
    localparam int CNT_MAX = (LAT_MAX > RST_CYC) ? LAT_MAX : RST_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    typedef enum logic [1:0] {IDLE, RST, RUN, DONE} state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [ID_W-1:0]  id_reg;
    logic             ptr_reg;
    logic             sel_reg;
    logic             err_reg;
    logic             sticky_reg;
    logic             live_reg;
    logic             grant_next;
    logic             accept;

    always_comb begin
        grant_next = req_valid[1];
        if (req_valid == 2'b11) begin
            grant_next = ptr_reg;
        end
    end

    // live_reg keeps req_ready low while reset is held, without using the
    // asynchronous reset net as a data input.
    assign accept = live_reg && (state_reg == IDLE) && (req_valid != 2'b00);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = accept && (grant_next == 1'(gi));
        end
    endgenerate

    always_ff @(posedge clk2 or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            id_reg     <= '0;
            ptr_reg    <= 1'b0;
            sel_reg    <= 1'b0;
            err_reg    <= 1'b0;
            sticky_reg <= 1'b0;
            live_reg   <= 1'b0;
        end else begin
            live_reg <= 1'b1;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        sel_reg   <= grant_next;
                        ptr_reg   <= ~grant_next;
                        cnt_reg   <= '0;
                        state_reg <= RST;
                    end
                end
                RST: begin
                    if (cnt_reg == CNT_W'(RST_CYC - 1)) begin
                        cnt_reg   <= '0;
                        state_reg <= RUN;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                RUN: begin
                    // A completion on the last allowed cycle beats the timeout.
                    if (fft_out_en) begin
                        err_reg   <= 1'b0;
                        state_reg <= DONE;
                    end else if (cnt_reg == CNT_W'(LAT_MAX - 1)) begin
                        err_reg    <= 1'b1;
                        sticky_reg <= 1'b1;
                        state_reg  <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        id_reg    <= id_reg + 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_load    = accept;
    assign in_sel     = sel_reg;
    assign fft_rst    = (state_reg == IDLE) || (state_reg == RST);
    assign out_valid  = (state_reg == DONE);
    assign out_src    = sel_reg;
    assign out_id     = id_reg;
    assign out_err    = err_reg;
    assign err_sticky = sticky_reg;
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_fft_frame_sched.sv
// Randomized bench for fft_frame_sched: the driver plays requesters and FFT core and
// pushes expected completions; an independent monitor consumes them with random backpressure.
module tb_fft_frame_sched;
    localparam int LAT_MAX = 16;
    localparam int RST_CYC = 1;
    localparam int ID_W    = 4;

    logic            clk2;
    logic            rst;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic            in_sel;
    logic            in_load;
    logic            fft_rst;
    logic            fft_out_en;
    logic            out_valid;
    logic            out_ready;
    logic            out_src;
    logic [ID_W-1:0] out_id;
    logic            out_err;
    logic            err_sticky;
    logic            busy;

    fft_frame_sched #(.LAT_MAX(LAT_MAX), .RST_CYC(RST_CYC), .ID_W(ID_W)) dut (
        .clk2(clk2), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .in_sel(in_sel), .in_load(in_load), .fft_rst(fft_rst), .fft_out_en(fft_out_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src), .out_id(out_id),
        .out_err(out_err), .err_sticky(err_sticky), .busy(busy)
    );

    typedef struct {
        int src;
        int id;
        int err;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ptr_m = 0;
    int   id_m = 0;
    int   last_a = -1;
    bit   force_ready = 0;

    initial begin
        clk2 = 1'b0;
        forever #5 clk2 = ~clk2;
    end

    always @(posedge clk2) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk2);
            fft_out_en = out_valid ? 1'($urandom_range(0, 1)) : 1'b0;
            req_valid  = force_ready ? 2'b11 : 2'($urandom_range(0, 3));
            n++;
        end while (busy && n < 300);
        if (busy) chk("idle_timeout", 1, 0);
    endtask

    // One frame: k < LAT_MAX pulses fft_out_en at RUN counter k, otherwise it times out.
    // rst_at > 0 asserts reset at that cycle after accept instead of finishing the frame.
    task automatic do_frame(input logic [1:0] pat, input int k, input int rst_at);
        int g;
        int last;
        int a;
        wait_idle();
        if (!force_ready && $urandom_range(0, 3) == 0) begin
            req_valid = 2'b00;
            #1;
            chk("no_req_ready", int'(req_ready), 0);
            @(negedge clk2);
            chk("no_grant_busy", int'(busy), 0);
        end
        req_valid  = pat;
        fft_out_en = 1'b0;
        #1;
        g = (pat == 2'b11) ? ptr_m : int'(pat[1]);
        chk("req_ready", int'(req_ready), 1 << g);
        chk("in_load", int'(in_load), 1);
        ptr_m = 1 - g;
        a = cyc;
        if (force_ready && last_a >= 0) chk("frame_period", a - last_a, RST_CYC + 3);
        last_a = a;
        if (rst_at <= 0) begin
            sb.push_back('{g, id_m, (k >= LAT_MAX) ? 1 : 0,
                           a + RST_CYC + 1 + ((k < LAT_MAX) ? k + 1 : LAT_MAX)});
            id_m = (id_m + 1) % (1 << ID_W);
        end
        last = (k < LAT_MAX) ? RST_CYC + 1 + k : RST_CYC + LAT_MAX;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk2);
            if (c == rst_at) begin
                rst = 1'b0;
                #1;
                chk("rst_fft_rst", int'(fft_rst), 1);
                chk("rst_busy", int'(busy), 0);
                chk("rst_out_valid", int'(out_valid), 0);
                chk("rst_req_ready", int'(req_ready), 0);
                chk("rst_out_id", int'(out_id), 0);
                chk("rst_err_sticky", int'(err_sticky), 0);
                ptr_m = 0;
                id_m  = 0;
                fft_out_en = 1'b0;
                @(negedge clk2);
                @(negedge clk2);
                rst = 1'b1;
                return;
            end
            if (c == 1) begin
                chk("in_sel", int'(in_sel), g);
                chk("req_ready_busy", int'(req_ready), 0);
                chk("busy", int'(busy), 1);
            end
            if (c == RST_CYC) chk("fft_rst_hold", int'(fft_rst), 1);
            if (c == RST_CYC + 1) chk("fft_rst_run", int'(fft_rst), 0);
            req_valid  = force_ready ? 2'b11 : 2'($urandom_range(0, 3));
            fft_out_en = (c <= RST_CYC) ? 1'($urandom_range(0, 1)) : 1'(c == last && k < LAT_MAX);
        end
    endtask

    // Completion monitor with random stalls.
    initial begin
        exp_t e;
        exp_t snap;
        int   hold = 0;
        bit   prev_valid = 0;
        int   sticky_m = 0;
        out_ready = 1'b0;
        forever begin
            @(negedge clk2);
            if (!rst) begin
                prev_valid = 0;
                sticky_m   = 0;
                hold       = 0;
                out_ready  = 1'b0;
                continue;
            end
            if (out_valid) begin
                chk("done_fft_rst", int'(fft_rst), 0);
                chk("done_req_ready", int'(req_ready), 0);
                if (!prev_valid) begin
                    $display("cycle %0d: completion src=%0d id=%0d err=%0d sticky=%0d",
                             cyc, out_src, out_id, out_err, err_sticky);
                    if (sb.size() == 0) begin
                        chk("unexpected_completion", 1, 0);
                        snap = '{int'(out_src), int'(out_id), int'(out_err), cyc};
                    end else begin
                        e = sb[0];
                        chk("done_cycle", cyc, e.cyc);
                        chk("out_src", int'(out_src), e.src);
                        chk("out_id", int'(out_id), e.id);
                        chk("out_err", int'(out_err), e.err);
                        sticky_m = sticky_m | e.err;
                        chk("err_sticky", int'(err_sticky), sticky_m);
                        snap = e;
                    end
                    hold = force_ready ? 0 : (($urandom_range(0, 2) == 0) ? $urandom_range(1, 12) : 0);
                end else begin
                    chk("hold_src", int'(out_src), snap.src);
                    chk("hold_id", int'(out_id), snap.id);
                    chk("hold_err", int'(out_err), snap.err);
                end
                out_ready = (hold == 0);
                if (hold > 0) hold--;
                if (out_ready) begin
                    if (sb.size() > 0) void'(sb.pop_front());
                    prev_valid = 0;
                end else begin
                    prev_valid = 1;
                end
            end else begin
                prev_valid = 0;
                out_ready  = force_ready ? 1'b1 : 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        rst        = 1'b0;
        req_valid  = 2'b11;
        fft_out_en = 1'b0;
        repeat (3) @(negedge clk2);
        #1;
        chk("reset_fft_rst", int'(fft_rst), 1);
        chk("reset_req_ready", int'(req_ready), 0);
        chk("reset_in_load", int'(in_load), 0);
        chk("reset_in_sel", int'(in_sel), 0);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_src", int'(out_src), 0);
        chk("reset_out_id", int'(out_id), 0);
        chk("reset_out_err", int'(out_err), 0);
        chk("reset_err_sticky", int'(err_sticky), 0);
        chk("reset_busy", int'(busy), 0);
        rst = 1'b1;

        force_ready = 1;
        for (int i = 0; i < 8; i++) do_frame(2'b11, 0, 0);
        force_ready = 0;

        do_frame(2'b01, 2, 0);
        do_frame(2'b11, LAT_MAX + 1, 0);
        do_frame(2'b11, LAT_MAX - 1, 0);
        do_frame(2'b10, 1, 0);
        for (int i = 0; i < 50; i++) begin
            do_frame(2'($urandom_range(1, 3)), $urandom_range(0, LAT_MAX + 2), 0);
        end

        do_frame(2'b01, LAT_MAX + 2, RST_CYC + 6);
        do_frame(2'b11, 0, 0);
        do_frame(2'b10, 3, 0);
        wait_idle();
        chk("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
